// File: rtl/haddr_slv_interface_p.sv
// haddr_slv_interface_p: AHB slave front end of an AHB-to-APB bridge (decode, 2-deep addr/data pipe, error reply).
// Latency: tempselx/valid combinational; Haddr1/Hwdata1 one accepted cycle, Haddr2/Hwdata2 two accepted cycles.
// Backpressure: Hreadyin=0 freezes the pipeline; optional error FSM built when HSLV_ERRRESP_EN is defined.
module haddr_slv_interface_p #(
  parameter int          AW   = 32,
  parameter int          DW   = 32,
  parameter int          NSLV = 3,
  parameter logic [31:0] BASE = 32'h8000_0000,
  parameter int          RGN  = 26
) (
  input  logic            Hclk,
  input  logic            Hresetin,
  input  logic            Hwrite,
  input  logic            Hreadyin,
  input  logic [1:0]      Htrans,
  input  logic [AW-1:0]   Haddr,
  input  logic [DW-1:0]   Hwdata,
  input  logic [DW-1:0]   Prdata,
  output logic [AW-1:0]   Haddr1,
  output logic [AW-1:0]   Haddr2,
  output logic [DW-1:0]   Hwdata1,
  output logic [DW-1:0]   Hwdata2,
  output logic            Hwritereg,
  output logic            valid,
  output logic [NSLV-1:0] tempselx,
  output logic [DW-1:0]   Hrdata,
  output logic [1:0]      Hresp,
  output logic            Hready_err
);

  // Decode arithmetic is done in 64 bits so the region end never overflows.
  localparam logic [63:0] BASE_X = 64'(BASE);
  localparam logic [63:0] REGION = 64'd1 << RGN;
  localparam logic [63:0] TOP    = BASE_X + 64'(NSLV) * REGION;
  localparam logic [63:0] SPACE  = 64'd1 << AW;

  // The decoded window must not wrap past the top of the address space.
  if (TOP > SPACE) begin : g_wrap_err
    $error("haddr_slv_interface_p: BASE + NSLV*2^RGN exceeds the 2^AW address space");
  end
  if (NSLV < 1 || NSLV > 8) begin : g_nslv_err
    $error("haddr_slv_interface_p: NSLV must be 1..8");
  end
  if (AW < 16 || AW > 32) begin : g_aw_err
    $error("haddr_slv_interface_p: AW must be 16..32");
  end
  if (DW != 8 && DW != 16 && DW != 32 && DW != 64) begin : g_dw_err
    $error("haddr_slv_interface_p: DW must be 8, 16, 32 or 64");
  end

  logic [63:0] addr_x;
  logic [63:0] slot;
  logic        in_range;
  logic        mapped;
  logic        active;

  assign addr_x   = {{(64-AW){1'b0}}, Haddr};
  assign in_range = (addr_x >= BASE_X) && (addr_x < TOP);
  assign slot     = (addr_x - BASE_X) >> RGN;
  assign active   = Htrans[1];            // NONSEQ (10) or SEQ (11)

  // One-hot region select; all-zero whenever the address falls outside the window.
  always_comb begin
    tempselx = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (in_range && (slot == 64'(i))) begin
        tempselx[i] = 1'b1;
      end
    end
  end

  assign mapped = |tempselx;
  assign valid  = Hreadyin & active & mapped;
  assign Hrdata = Prdata;

  // Address/data/direction pipeline, advancing only on accepted (Hreadyin=1) cycles.
  always_ff @(posedge Hclk or negedge Hresetin) begin
    if (!Hresetin) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwdata2   <= '0;
      Hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwdata2   <= Hwdata1;
      Hwritereg <= Hwrite;
    end
  end

`ifdef HSLV_ERRRESP_EN
  typedef enum logic [1:0] {ST_OKAY = 2'd0, ST_ERR1 = 2'd1, ST_ERR2 = 2'd2} err_state_t;

  err_state_t state;
  err_state_t state_nxt;
  logic       err_start;

  // An accepted active transfer that hits no slave starts an ERROR response.
  assign err_start = Hreadyin & active & ~mapped;

  // Error FSM state register.
  always_ff @(posedge Hclk or negedge Hresetin) begin
    if (!Hresetin) begin
      state <= ST_OKAY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: ERR1 is the wait cycle, ERR2 the final cycle (which may chain into a new error).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_OKAY: state_nxt = err_start ? ST_ERR1 : ST_OKAY;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = err_start ? ST_ERR1 : ST_OKAY;
      default: state_nxt = ST_OKAY;
    endcase
  end

  // Two-cycle AHB ERROR: first cycle holds the bus, second releases it.
  always_comb begin
    Hresp      = 2'b00;
    Hready_err = 1'b1;
    case (state)
      ST_ERR1: begin
        Hresp      = 2'b01;
        Hready_err = 1'b0;
      end
      ST_ERR2: begin
        Hresp      = 2'b01;
        Hready_err = 1'b1;
      end
      default: begin
        Hresp      = 2'b00;
        Hready_err = 1'b1;
      end
    endcase
  end
`else
  // Without the error responder unmapped transfers are dropped silently.
  assign Hresp      = 2'b00;
  assign Hready_err = 1'b1;
`endif

endmodule

// File: tb/tb_haddr_slv_interface_p.sv
`timescale 1ns/1ps
module tb_haddr_slv_interface_p;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic        Hclk = 1'b0;
  logic        Hresetin = 1'b0;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b0;
  logic [1:0]  Htrans = IDLE;
  logic [31:0] Haddr = '0;
  logic [31:0] Hwdata = '0;
  logic [31:0] Prdata = '0;
  logic [31:0] Haddr_b = '0;

  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic        Hwritereg, valid, Hready_err;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  logic [31:0] Haddr1_b, Haddr2_b, Hwdata1_b, Hwdata2_b, Hrdata_b;
  logic        Hwritereg_b, valid_b, Hready_err_b;
  logic [7:0]  tempselx_b;
  logic [1:0]  Hresp_b;

  always #5 Hclk = ~Hclk;

  haddr_slv_interface_p dut (
    .Hclk(Hclk), .Hresetin(Hresetin), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
    .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1), .Hwdata2(Hwdata2),
    .Hwritereg(Hwritereg), .valid(valid), .tempselx(tempselx), .Hrdata(Hrdata),
    .Hresp(Hresp), .Hready_err(Hready_err)
  );

  haddr_slv_interface_p #(.NSLV(8), .RGN(20)) dut_b (
    .Hclk(Hclk), .Hresetin(Hresetin), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
    .Htrans(Htrans), .Haddr(Haddr_b), .Hwdata(Hwdata), .Prdata(Prdata),
    .Haddr1(Haddr1_b), .Haddr2(Haddr2_b), .Hwdata1(Hwdata1_b), .Hwdata2(Hwdata2_b),
    .Hwritereg(Hwritereg_b), .valid(valid_b), .tempselx(tempselx_b), .Hrdata(Hrdata_b),
    .Hresp(Hresp_b), .Hready_err(Hready_err_b)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] wdata;
    logic        rdy;
    logic [2:0]  exp_sel;
    logic        exp_valid;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } pipe_t;

  vec_t  vecs[14];
  pipe_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [31:0] d, input logic r);
    Haddr    = a;
    Htrans   = t;
    Hwrite   = w;
    Hwdata   = d;
    Hreadyin = r;
    Prdata   = $urandom;
  endtask

  // Scoreboard: sb[1] is the newest accepted beat (stage 1), sb[0] the one before (stage 2).
  task automatic sb_clear();
    sb.delete();
    sb.push_back('{32'h0, 1'b0, 32'h0});
    sb.push_back('{32'h0, 1'b0, 32'h0});
  endtask

  task automatic tick();
    pipe_t e1, e2;
    @(posedge Hclk);
    if (Hreadyin === 1'b1) begin
      sb.push_back('{Haddr, Hwrite, Hwdata});
      void'(sb.pop_front());
    end
    #1;
    e1 = sb[1];
    e2 = sb[0];
    chk("Haddr1", Haddr1, e1.addr);
    chk("Haddr2", Haddr2, e2.addr);
    chk("Hwdata1", Hwdata1, e1.wdata);
    chk("Hwdata2", Hwdata2, e2.wdata);
    chk("Hwritereg", Hwritereg, e1.wr);
  endtask

  task automatic resp_chk(input string nm, input logic [1:0] er, input logic erdy, input logic ev);
    @(negedge Hclk);
    chk({nm, ".Hresp"}, Hresp, er);
    chk({nm, ".Hready_err"}, Hready_err, erdy);
    chk({nm, ".valid"}, valid, ev);
    tick();
  endtask

  task automatic do_reset();
    #2;
    Hresetin = 1'b0;
    drive(32'h0, IDLE, 1'b0, 32'h0, 1'b0);
    sb_clear();
    #3;
    @(negedge Hclk);
    chk("rst.Hresp", Hresp, 2'b00);
    chk("rst.Hready_err", Hready_err, 1'b1);
    Hresetin = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{32'h8000_0000, NONSEQ, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'b001, 1'b1};
    vecs[1]  = '{32'h8400_0000, NONSEQ, 1'b0, 32'h1111_2222, 1'b1, 3'b010, 1'b1};
    vecs[2]  = '{32'h87FF_FFFC, SEQ,    1'b1, 32'h3333_4444, 1'b1, 3'b010, 1'b1};
    vecs[3]  = '{32'h8800_0000, SEQ,    1'b0, 32'h5555_6666, 1'b1, 3'b100, 1'b1};
    vecs[4]  = '{32'h8BFF_FFFF, NONSEQ, 1'b1, 32'h7777_8888, 1'b1, 3'b100, 1'b1};
    vecs[5]  = '{32'h8C00_0000, NONSEQ, 1'b0, 32'h9999_AAAA, 1'b1, 3'b000, 1'b0};
    vecs[6]  = '{32'h7FFF_FFFF, NONSEQ, 1'b1, 32'hBBBB_CCCC, 1'b1, 3'b000, 1'b0};
    vecs[7]  = '{32'h8000_0000, IDLE,   1'b0, 32'hCAFE_0001, 1'b1, 3'b001, 1'b0};
    vecs[8]  = '{32'h8400_0010, BUSY,   1'b1, 32'hCAFE_0002, 1'b1, 3'b010, 1'b0};
    vecs[9]  = '{32'h8400_0000, NONSEQ, 1'b0, 32'h0BAD_0001, 1'b0, 3'b010, 1'b0};
    vecs[10] = '{32'h8800_0004, NONSEQ, 1'b1, 32'h0BAD_0002, 1'b0, 3'b100, 1'b0};
    vecs[11] = '{32'h8800_0008, SEQ,    1'b0, 32'h0BAD_0003, 1'b0, 3'b100, 1'b0};
    vecs[12] = '{32'h0000_0000, NONSEQ, 1'b1, 32'h1234_5678, 1'b1, 3'b000, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF, SEQ,    1'b0, 32'h8765_4321, 1'b1, 3'b000, 1'b0};

    do_reset();

    // Main decode / pipeline table.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].addr, vecs[i].trans, vecs[i].wr, vecs[i].wdata, vecs[i].rdy);
      @(negedge Hclk);
      chk($sformatf("v%0d.tempselx", i), tempselx, vecs[i].exp_sel);
      chk($sformatf("v%0d.valid", i), valid, vecs[i].exp_valid);
      chk($sformatf("v%0d.Hrdata", i), Hrdata, Prdata);
`ifndef HSLV_ERRRESP_EN
      chk($sformatf("v%0d.Hresp", i), Hresp, 2'b00);
      chk($sformatf("v%0d.Hready_err", i), Hready_err, 1'b1);
`endif
      tick();
    end

    do_reset();
`ifdef HSLV_ERRRESP_EN
    // Single error: ERR1 (hold), ERR2 (release), back to OKAY.
    drive(32'h8C00_0000, NONSEQ, 1'b0, 32'h0, 1'b1);
    resp_chk("err.issue", 2'b00, 1'b1, 1'b0);
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b0);
    resp_chk("err.err1", 2'b01, 1'b0, 1'b0);
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b1);
    resp_chk("err.err2", 2'b01, 1'b1, 1'b0);
    resp_chk("err.okay", 2'b00, 1'b1, 1'b0);
    // Back-to-back errors: a new unmapped transfer in ERR2 re-enters ERR1.
    drive(32'h8C00_0000, NONSEQ, 1'b0, 32'h0, 1'b1);
    resp_chk("b2b.issue", 2'b00, 1'b1, 1'b0);
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b0);
    resp_chk("b2b.err1a", 2'b01, 1'b0, 1'b0);
    drive(32'h9000_0000, SEQ, 1'b0, 32'h0, 1'b1);
    resp_chk("b2b.err2a", 2'b01, 1'b1, 1'b0);
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b0);
    resp_chk("b2b.err1b", 2'b01, 1'b0, 1'b0);
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b1);
    resp_chk("b2b.err2b", 2'b01, 1'b1, 1'b0);
    // IDLE/BUSY to unmapped space stays OKAY.
    drive(32'h8C00_0000, IDLE, 1'b0, 32'h0, 1'b1);
    resp_chk("idle.unmap", 2'b00, 1'b1, 1'b0);
    drive(32'h8C00_0000, BUSY, 1'b0, 32'h0, 1'b1);
    resp_chk("busy.unmap", 2'b00, 1'b1, 1'b0);
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b1);
    resp_chk("busy.after", 2'b00, 1'b1, 1'b0);
`else
    // Unmapped active transfers are dropped: always OKAY, never valid.
    for (int i = 0; i < 3; i++) begin
      drive(32'h8C00_0000 + 32'(i * 4), NONSEQ, 1'b0, 32'h0, 1'b1);
      resp_chk($sformatf("drop%0d", i), 2'b00, 1'b1, 1'b0);
    end
`endif

    // Asynchronous reset in the middle of an error response.
    do_reset();
    drive(32'h8C00_0000, NONSEQ, 1'b1, 32'h1234_5678, 1'b1);
    tick();
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b0);
    #1;
`ifdef HSLV_ERRRESP_EN
    chk("arst.pre.Hresp", Hresp, 2'b01);
    chk("arst.pre.Hready_err", Hready_err, 1'b0);
`endif
    #1;
    Hresetin = 1'b0;
    #1;
    chk("arst.Hresp", Hresp, 2'b00);
    chk("arst.Hready_err", Hready_err, 1'b1);
    chk("arst.Haddr1", Haddr1, 32'h0);
    chk("arst.Haddr2", Haddr2, 32'h0);
    chk("arst.Hwdata1", Hwdata1, 32'h0);
    chk("arst.Hwdata2", Hwdata2, 32'h0);
    chk("arst.Hwritereg", Hwritereg, 1'b0);
    sb_clear();
    @(negedge Hclk);
    Hresetin = 1'b1;
    drive(32'h8000_0040, NONSEQ, 1'b1, 32'hA5A5_5A5A, 1'b1);
    tick();
    drive(32'h8000_0000, IDLE, 1'b0, 32'h0, 1'b1);
    resp_chk("arst.after", 2'b00, 1'b1, 1'b0);

    // Eight-slave instance: sweep region bases, k=8 is just past the window.
    for (int k = 0; k <= 8; k++) begin
      logic [7:0] esel;
      esel = (k < 8) ? 8'(1 << k) : 8'h00;
      drive(32'h8000_0000, NONSEQ, 1'b0, 32'(k), 1'b1);
      Haddr_b = 32'h8000_0000 + (32'(k) << 20);
      @(negedge Hclk);
      chk($sformatf("sweep%0d.tempselx", k), tempselx_b, esel);
      chk($sformatf("sweep%0d.valid", k), valid_b, (k < 8));
`ifndef HSLV_ERRRESP_EN
      chk($sformatf("sweep%0d.Hresp", k), Hresp_b, 2'b00);
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/haddr_slv_interface_p.md
HADDR_SLV_INTERFACE_P -- requirements
Module: haddr_slv_interface_p

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width (16..32).
REQ-002 SHALL have parameter DW, default 32, meaning data width (8, 16, 32 or 64).
REQ-003 SHALL have parameter NSLV, default 3, meaning APB slave count (1..8).
REQ-004 SHALL have parameter BASE, default 32'h8000_0000, meaning decode base address.
REQ-005 SHALL have parameter RGN, default 26, meaning log2 of region size per slave.
REQ-006 SHALL have port Hclk, in, 1, the single clock; all flops rise on it.
REQ-007 SHALL have port Hresetin, in, 1, asynchronous active-low reset.
REQ-008 SHALL have ports Hwrite in 1, Hreadyin in 1, Htrans in 2: AHB control.
REQ-009 SHALL have ports Haddr in AW, Hwdata in DW and Prdata in DW.
REQ-010 SHALL have ports Haddr1 out AW, Haddr2 out AW, Hwdata1 out DW and Hwdata2 out DW: pipeline stages.
REQ-011 SHALL have port Hwritereg, out, 1, registered Hwrite.
REQ-012 SHALL have port valid, out, 1, mapped active transfer.
REQ-013 SHALL have port tempselx, out, NSLV, one-hot slave select.
REQ-014 SHALL have port Hrdata, out, DW, equal to Prdata.
REQ-015 SHALL have port Hresp, out, 2, AHB response.
REQ-016 SHALL have port Hready_err, out, 1, the error-phase ready; 1 outside errors.

Function
REQ-017 Slave i SHALL decode Haddr in [BASE+i*2^RGN, BASE+(i+1)*2^RGN-1] (half-open regions, no overlap); the decode is combinational.
REQ-018 tempselx[i] SHALL be 1 only for the matched region; it SHALL be all-zero when unmapped; at most one bit SHALL be set.
REQ-019 "active" SHALL mean Htrans equal to NONSEQ (2'b10) or SEQ (2'b11).
REQ-020 valid SHALL be combinational: Hreadyin, active, and the address mapped.
REQ-021 When Hreadyin=1, each rising edge SHALL load Haddr1<=Haddr, Haddr2<=Haddr1, Hwritereg<=Hwrite, Hwdata1<=Hwdata and Hwdata2<=Hwdata1.
REQ-022 When Hreadyin=0, all pipeline registers SHALL hold.
REQ-023 The latency from Haddr to Haddr1 SHALL be 1 cycle, and to Haddr2 SHALL be 2 accepted cycles; data SHALL behave likewise.
REQ-024 The error FSM SHALL have states OKAY, ERR1 and ERR2.
REQ-025 In OKAY the outputs SHALL be Hresp=2'b00 and Hready_err=1.
REQ-026 In OKAY, Hreadyin=1 with active and unmapped SHALL move the FSM to ERR1; otherwise the FSM SHALL stay in OKAY.
REQ-027 ERR1 SHALL drive Hresp=2'b01 and Hready_err=0, and SHALL always move to ERR2.
REQ-028 ERR2 SHALL drive Hresp=2'b01 and Hready_err=1, and SHALL move to OKAY.
REQ-029 In ERR2, a new active unmapped transfer with Hreadyin=1 SHALL move the FSM to ERR1, for back-to-back errors.
REQ-030 An unmapped transfer SHALL never assert valid or any tempselx bit, and SHALL not be forwarded.
REQ-031 An IDLE or BUSY transfer to an unmapped address SHALL get an OKAY response.
REQ-032 A wrap at the top of the address space (BASE+NSLV*2^RGN > 2^AW) SHALL be a parameter error, flagged at elaboration.

Reset
REQ-033 Hresetin low SHALL immediately clear Haddr1, Haddr2, Hwdata1, Hwdata2 and Hwritereg to 0 and force the FSM to OKAY, so that Hresp=00 and Hready_err=1.
REQ-034 A reset mid-error SHALL abort the response; the first edge after deassertion SHALL sample normally.

Configuration
REQ-035 Macro HSLV_ERRRESP_EN defined SHALL build the error FSM as specified.
REQ-036 With HSLV_ERRRESP_EN undefined: no FSM; Hresp SHALL be constant 2'b00, Hready_err constant 1, and unmapped transfers SHALL be silently dropped (valid=0).

Verification
REQ-037 Defaults; Haddr=32'h8400_0000, NONSEQ, Hreadyin=1 -> tempselx=3'b010, valid=1; Haddr1=8400_0000 after 1 edge, Haddr2 after 2.
REQ-038 Haddr=32'h8C00_0000, NONSEQ, macro on -> next cycle Hresp=01/Hready_err=0, then Hresp=01/Hready_err=1, then OKAY; valid stays 0.
REQ-039 Hreadyin=0 for 3 cycles with Hwdata changing -> Hwdata1, Hwdata2, Haddr1 and Hwritereg unchanged.
REQ-040 Hwrite=1, Hwdata=32'hDEAD_BEEF, Hreadyin=1 -> Hwritereg=1 and Hwdata1=DEAD_BEEF after 1 edge; Hwdata2=DEAD_BEEF after 2.
REQ-041 Hresetin low during ERR1 (unsynchronised to Hclk) -> Hresp=00, Hready_err=1 and all registers 0 without a clock edge.
REQ-042 NSLV=8, RGN=20, macro off; sweep Haddr=BASE+k*2^20 for k=0..8 -> one-hot k for k<8, all-zero at k=8, and Hresp always 00.
